// File: rtl/zx_tape_player.sv
// zx_tape_player: plays tape-buffer bytes as ZX80/ZX81 cassette pulse trains; TAPE_PLAYER_TURBO_EN adds a turbo input.
// Latency: first pulse TL ticks plus a few clk after start; no backpressure, rd_data is consumed 2 clk after rd_addr settles.
module zx_tape_player #(
  parameter int         CE_HZ     = 6500000,
  parameter int         ADDR_W    = 14,
  parameter int         PULSE_US  = 150,
  parameter int         GAP_US    = 1300,
  parameter int         LEAD_MS   = 1000,
  parameter logic [7:0] NAME_BYTE = 8'hA6
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic              zx81,
`ifdef TAPE_PLAYER_TURBO_EN
  input  logic              turbo,
`endif
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  localparam longint TP_L = (longint'(PULSE_US) * longint'(CE_HZ)) / 64'sd1000000;
  localparam longint TG_L = (longint'(GAP_US) * longint'(CE_HZ)) / 64'sd1000000;
  localparam longint TL_L = (longint'(LEAD_MS) * longint'(CE_HZ)) / 64'sd1000;
  localparam int     TW   = $clog2(TL_L + 64'sd1);

  localparam logic [TW-1:0] TP_N = TW'(TP_L);
  localparam logic [TW-1:0] TG_N = TW'(TG_L);
  localparam logic [TW-1:0] TL_N = TW'(TL_L);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_FETCH, S_BIT, S_PHI, S_PLO, S_GAP, S_TRAIL
  } state_t;

  state_t            state;
  logic [TW-1:0]     tmr;
  logic [3:0]        pcnt;
  logic [2:0]        bit_idx;
  logic [7:0]        sr;
  logic              is_name;
  logic              fcnt;
  logic [ADDR_W-1:0] len_r;
  logic              mode_r;
  logic [ADDR_W-1:0] next_addr;
  logic              tmr_last;

  logic [TW-1:0] tp_d, tg_d, tl_d, tl_start;

`ifdef TAPE_PLAYER_TURBO_EN
  logic turbo_r;
  assign tp_d     = turbo_r ? (TP_N >> 2) : TP_N;
  assign tg_d     = turbo_r ? (TG_N >> 2) : TG_N;
  assign tl_d     = turbo_r ? (TL_N >> 2) : TL_N;
  // The lead timer is loaded before turbo_r exists, so use the live input.
  assign tl_start = turbo ? (TL_N >> 2) : TL_N;
`else
  assign tp_d     = TP_N;
  assign tg_d     = TG_N;
  assign tl_d     = TL_N;
  assign tl_start = TL_N;
`endif

  assign next_addr = rd_addr + ADDR_W'(1);
  // A zero-length duration still costs one tick rather than wrapping the timer.
  assign tmr_last  = (tmr <= TW'(1));

  always_ff @(posedge clk_sys) begin
    done <= 1'b0;
    if (reset) begin
      state    <= S_IDLE;
      tape_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      tmr      <= '0;
      pcnt     <= '0;
      bit_idx  <= '0;
      sr       <= '0;
      is_name  <= 1'b0;
      fcnt     <= 1'b0;
      len_r    <= '0;
      mode_r   <= 1'b0;
`ifdef TAPE_PLAYER_TURBO_EN
      turbo_r  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_r   <= len;
            mode_r  <= zx81;
`ifdef TAPE_PLAYER_TURBO_EN
            turbo_r <= turbo;
`endif
            rd_addr <= '0;
            busy    <= 1'b1;
            tmr     <= tl_start;
            state   <= S_LEAD;
          end
        end

        S_LEAD: begin
          if (ce) begin
            if (tmr_last) begin
              bit_idx <= '0;
              if (mode_r) begin
                sr      <= NAME_BYTE;
                is_name <= 1'b1;
                state   <= S_BIT;
              end else if (len_r == '0) begin
                tmr   <= tl_d;
                state <= S_TRAIL;
              end else begin
                fcnt  <= 1'b0;
                state <= S_FETCH;
              end
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end

        S_FETCH: begin
          if (fcnt) begin
            sr      <= rd_data;
            is_name <= 1'b0;
            bit_idx <= '0;
            state   <= S_BIT;
          end else begin
            fcnt <= 1'b1;
          end
        end

        // Waiting for ce here keeps every high pulse aligned to whole ce periods.
        S_BIT: begin
          if (ce) begin
            pcnt     <= sr[7] ? 4'd9 : 4'd4;
            tmr      <= tp_d;
            tape_out <= 1'b1;
            state    <= S_PHI;
          end
        end

        S_PHI: begin
          if (ce) begin
            if (tmr_last) begin
              tape_out <= 1'b0;
              tmr      <= tp_d;
              state    <= S_PLO;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end

        S_PLO: begin
          if (ce) begin
            if (tmr_last) begin
              pcnt <= pcnt - 4'd1;
              if (pcnt == 4'd1) begin
                tmr   <= tg_d;
                state <= S_GAP;
              end else begin
                tmr      <= tp_d;
                tape_out <= 1'b1;
                state    <= S_PHI;
              end
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end

        S_GAP: begin
          if (ce) begin
            if (tmr_last) begin
              if (bit_idx != 3'd7) begin
                sr      <= {sr[6:0], 1'b0};
                bit_idx <= bit_idx + 3'd1;
                state   <= S_BIT;
              end else if (is_name) begin
                is_name <= 1'b0;
                fcnt    <= 1'b0;
                if (len_r == '0) begin
                  tmr   <= tl_d;
                  state <= S_TRAIL;
                end else begin
                  state <= S_FETCH;
                end
              end else begin
                rd_addr <= next_addr;
                fcnt    <= 1'b0;
                if (next_addr == len_r) begin
                  tmr   <= tl_d;
                  state <= S_TRAIL;
                end else begin
                  state <= S_FETCH;
                end
              end
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end

        S_TRAIL: begin
          if (ce) begin
            if (tmr_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zx_tape_player.sv
// Bench for zx_tape_player: records tape_out run lengths and checks pulse trains against hand-derived timings.
module tb_zx_tape_player;
  localparam int CE_HZ    = 1000000;
  localparam int ADDR_W   = 14;
  localparam int PULSE_US = 30;
  localparam int GAP_US   = 260;
  localparam int LEAD_MS  = 1;
  // ce ticks for the parameters above: 30*1e6/1e6, 260*1e6/1e6, 1*1e6/1e3.
  localparam int TP = 30;
  localparam int TG = 260;
  localparam int TL = 1000;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              ce      = 1'b1;
  logic              start   = 1'b0;
  logic              zx81    = 1'b0;
  logic [ADDR_W-1:0] len     = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = 8'h00;
  logic              tape_out;
  logic              busy;
  logic              done;
`ifdef TAPE_PLAYER_TURBO_EN
  logic              turbo   = 1'b0;
`endif

  logic [7:0] mem [0:3];

  zx_tape_player #(
    .CE_HZ(CE_HZ), .ADDR_W(ADDR_W), .PULSE_US(PULSE_US), .GAP_US(GAP_US),
    .LEAD_MS(LEAD_MS), .NAME_BYTE(8'hA6)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ce(ce),
    .start(start),
    .zx81(zx81),
`ifdef TAPE_PLAYER_TURBO_EN
    .turbo(turbo),
`endif
    .len(len),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tape_out(tape_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) rd_data <= mem[rd_addr[1:0]];

  int ce_div = 1;
  int ce_ph  = 0;
  always @(negedge clk_sys) begin
    ce_ph = (ce_ph + 1) % ce_div;
    ce    = (ce_ph == 0);
  end

  int   n_tot = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;
  logic last_lvl = 1'b0;
  int   run_len = 0, done_cnt = 0, trail_len = -1;
  int   highs[$], lows[$], addr_log[$];
  int   groups[$], exp_g[$];
  int   hi_min, hi_max, in_min, in_max, gap_min, gap_max;

  always @(negedge clk_sys) begin
    if (mon_on) begin
      if (tape_out !== last_lvl) begin
        if (last_lvl) highs.push_back(run_len);
        else lows.push_back(run_len);
        last_lvl = tape_out;
        run_len  = 1;
      end else begin
        run_len++;
      end
      if (addr_log.size() == 0 || int'(rd_addr) != addr_log[addr_log.size()-1])
        addr_log.push_back(int'(rd_addr));
      if (done) begin
        done_cnt++;
        trail_len = run_len;
      end
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lim(input longint x, input longint lo, input longint hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int low_at(input int i);
    return (i < lows.size()) ? lows[i] : -1;
  endfunction

  function automatic int grp_at(input int i);
    return (i < groups.size()) ? groups[i] : -1;
  endfunction

  function automatic int addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : -1;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      #1;
    end
  endtask

  task automatic arm();
    highs.delete(); lows.delete(); addr_log.delete();
    run_len = 0; last_lvl = 1'b0; done_cnt = 0; trail_len = -1;
    mon_on = 1'b1;
  endtask

  task automatic play(input bit mode, input int n, output int cyc);
    zx81 = mode;
    len  = ADDR_W'(n);
    arm();
    start = 1'b1;
    step(1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40000) begin
      step(1);
      cyc++;
    end
  endtask

  // Split the recorded pulses into bits: a low longer than two pulse units separates bits.
  task automatic analyse(input int unit);
    groups.delete();
    hi_min = 1 << 30; hi_max = 0; in_min = 1 << 30; in_max = 0; gap_min = 1 << 30; gap_max = 0;
    for (int i = 0; i < highs.size(); i++) begin
      if (highs[i] < hi_min) hi_min = highs[i];
      if (highs[i] > hi_max) hi_max = highs[i];
      if (i == 0 || lows[i] > 2 * unit) begin
        groups.push_back(1);
        if (i > 0) begin
          if (lows[i] < gap_min) gap_min = lows[i];
          if (lows[i] > gap_max) gap_max = lows[i];
        end
      end else begin
        groups[groups.size()-1] += 1;
        if (lows[i] < in_min) in_min = lows[i];
        if (lows[i] > in_max) in_max = lows[i];
      end
    end
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) exp_g.push_back(v[b] ? 9 : 4);
  endtask

  task automatic cmp_groups(input string p);
    chk({p, "_nbits"}, groups.size(), exp_g.size());
    for (int i = 0; i < exp_g.size(); i++)
      chk($sformatf("%s_bit%0d_pulses", p, i), grp_at(i), exp_g[i]);
  endtask

  task automatic chk_train(input string p, input int unit, input int gap_lo, input int gap_hi);
    chk({p, "_hi_min"}, hi_min, unit);
    chk({p, "_hi_max"}, hi_max, unit);
    chk({p, "_lo_min"}, in_min, unit);
    chk({p, "_lo_max"}, in_max, unit);
    chk({p, "_gap_min"}, gap_min, lim(gap_min, gap_lo, gap_hi));
    chk({p, "_gap_max"}, gap_max, lim(gap_max, gap_lo, gap_hi));
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;

    step(3);
    chk("rst_tape", tape_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rd_addr, 0);
    reset = 1'b0;
    step(2);

    // ZX80, one byte 0x80: one long bit then seven short ones.
    mem[0] = 8'h80;
    play(1'b0, 1, cyc);
    chk("t1_done", done, 1);
    analyse(TP);
    exp_g.delete();
    add_byte(8'h80);
    cmp_groups("t1");
    chk_train("t1", TP, TP + TG, TP + TG + 4);
    chk("t1_lead", low_at(0), lim(low_at(0), TL, TL + 6));
    chk("t1_trail", trail_len, TP + TG + TL + 1);
    step(2);
    chk("t1_busy_end", busy, 0);
    chk("t1_done_once", done_cnt, 1);

    // ZX81, two bytes: name byte first, then 0x00 and 0xFF.
    mem[0] = 8'h00;
    mem[1] = 8'hFF;
    play(1'b1, 2, cyc);
    chk("t2_done", done, 1);
    analyse(TP);
    exp_g.delete();
    add_byte(8'hA6);
    add_byte(8'h00);
    add_byte(8'hFF);
    cmp_groups("t2");
    chk_train("t2", TP, TP + TG, TP + TG + 4);
    chk("t2_addr0", addr_at(0), 0);
    chk("t2_addr1", addr_at(1), 1);

    // Empty buffer: lead straight into trail.
    play(1'b0, 0, cyc);
    chk("t3_cycles", cyc, 2 * TL);
    chk("t3_pulses", highs.size(), 0);
    step(2);
    chk("t3_busy_end", busy, 0);

    // Reset in the middle of the third pulse, then replay.
    mem[0] = 8'h80;
    zx81 = 1'b0;
    len = ADDR_W'(1);
    arm();
    start = 1'b1;
    step(1);
    start = 1'b0;
    cyc = 0;
    while (lows.size() < 3 && cyc < 5000) begin
      step(1);
      cyc++;
    end
    step(TP / 2);
    chk("t4_in_pulse", tape_out, 1);
    reset = 1'b1;
    step(1);
    chk("t4_rst_tape", tape_out, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    reset = 1'b0;
    step(2 * TL + 200);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_quiet", lows.size(), 3);
    play(1'b0, 1, cyc);
    chk("t4_replay_done", done, 1);
    analyse(TP);
    exp_g.delete();
    add_byte(8'h80);
    cmp_groups("t4");
    chk("t4_addr0", addr_at(0), 0);
    chk("t4_lead", low_at(0), lim(low_at(0), TL, TL + 6));

    // ce at 1-in-8, with a second start during the first pulse.
    ce_div = 8;
    step(2);
    arm();
    start = 1'b1;
    step(1);
    start = 1'b0;
    cyc = 0;
    while (lows.size() < 1 && cyc < 20000) begin
      step(1);
      cyc++;
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    cyc = 0;
    while (lows.size() < 10 && cyc < 20000) begin
      step(1);
      cyc++;
    end
    chk("t5_busy", busy, 1);
    analyse(TP * 8);
    chk("t5_first_bit", grp_at(0), 9);
    chk("t5_hi_min", hi_min, TP * 8);
    chk("t5_hi_max", hi_max, TP * 8);
    chk("t5_lo_min", in_min, TP * 8);
    chk("t5_lo_max", in_max, TP * 8);
    chk("t5_gap", low_at(9), lim(low_at(9), (TP + TG) * 8, (TP + TG + 1) * 8));
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    ce_div = 1;
    step(2);

`ifdef TAPE_PLAYER_TURBO_EN
    // Turbo: every duration quartered (30>>2=7, 260>>2=65, 1000>>2=250).
    turbo = 1'b1;
    play(1'b0, 1, cyc);
    turbo = 1'b0;
    chk("t6_done", done, 1);
    analyse(TP / 4);
    exp_g.delete();
    add_byte(8'h80);
    cmp_groups("t6");
    chk_train("t6", TP / 4, TP / 4 + TG / 4, TP / 4 + TG / 4 + 4);
    chk("t6_lead", low_at(0), lim(low_at(0), TL / 4, TL / 4 + 6));
    chk("t6_trail", trail_len, TP / 4 + TG / 4 + TL / 4 + 1);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
